mul_chain_bf16: RTL and testbench

- Pipelined chain of six bfloat16 multipliers computing the power series p_k = a * b^(k+1), k = 0..5, from one packed operand pair per cycle.
- Every stage result is exposed on its own 32-bit lane with its own valid strobe.
- Used as the product-node datapath of the probabilistic-circuit evaluator; accepts one new input per cycle (fully pipelined, no back-pressure).

---
 rtl/mul_chain_pkg.sv | 23 ++
 rtl/mul_chain_bf16_mul.sv | 81 ++++++++
 rtl/mul_chain_bf16.sv | 83 ++++++++
 tb/tb_mul_chain_bf16.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_chain_pkg.sv
// Shared types and constants for the bf16 power-series multiplier chain.
package mul_chain_pkg;

   localparam int N_STAGES_DEFAULT = 6;
   localparam int EXP_BIAS         = 127;

   localparam logic [15:0] BF16_QNAN = 16'h7FC0;
   localparam logic [14:0] BF16_MAXF = 15'h7F7F;

   typedef struct packed {
      logic       sign;
      logic [7:0] exp;
      logic [6:0] frac;
   } bf16_t;

   typedef enum logic [1:0] {
      RNE = 2'b00,
      RTZ = 2'b01,
      RUP = 2'b10,
      RDN = 2'b11
   } round_mode_e;

endpackage

// File: rtl/mul_chain_bf16_mul.sv
// Combinational bf16 x bf16 multiply with selectable rounding; subnormals read as zero
// and tiny results flush to signed zero.
module bf16_mul
   import mul_chain_pkg::*;
(
   input  bf16_t       a,
   input  bf16_t       b,
   input  round_mode_e mode,
   output bf16_t       result
);

   logic        sign;
   logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic [15:0] prod;
   logic [6:0]  frac_pre;
   logic        guard, sticky, inc;
   logic [7:0]  frac_sum;
   logic [9:0]  exp_sum, exp_norm, exp_rnd;
   logic        ovf, unf;

   assign sign   = a.sign ^ b.sign;
   assign a_zero = (a.exp == 8'h00);
   assign b_zero = (b.exp == 8'h00);
   assign a_inf  = (a.exp == 8'hFF) && (a.frac == 7'h00);
   assign b_inf  = (b.exp == 8'hFF) && (b.frac == 7'h00);
   assign a_nan  = (a.exp == 8'hFF) && (a.frac != 7'h00);
   assign b_nan  = (b.exp == 8'hFF) && (b.frac != 7'h00);

   // Product of 1.x mantissas lies in [1,4); prod[15] marks the one-bit renormalize.
   assign prod     = {8'h00, 1'b1, a.frac} * {8'h00, 1'b1, b.frac};
   assign frac_pre = prod[15] ? prod[14:8] : prod[13:7];
   assign guard    = prod[15] ? prod[7]    : prod[6];
   assign sticky   = prod[15] ? |prod[6:0] : |prod[5:0];

   // Exponent is kept as a 10-bit two's-complement value so under/overflow are plain compares.
   assign exp_sum  = {2'b00, a.exp} + {2'b00, b.exp} - 10'(EXP_BIAS);
   assign exp_norm = exp_sum + {9'h000, prod[15]};

   // Round-increment decision for the selected mode.
   always_comb begin
      inc = 1'b0;
      case (mode)
         RNE:     inc = guard & (sticky | frac_pre[0]);
         RTZ:     inc = 1'b0;
         RUP:     inc = ~sign & (guard | sticky);
         RDN:     inc = sign & (guard | sticky);
         default: inc = 1'b0;
      endcase
   end

   // A carry out of the fraction means the mantissa rolled to 2.0: fraction wraps to zero.
   assign frac_sum = {1'b0, frac_pre} + {7'h00, inc};
   assign exp_rnd  = exp_norm + {9'h000, frac_sum[7]};
   assign ovf      = ($signed(exp_rnd) >= 10'sd255);
   assign unf      = ($signed(exp_rnd) < 10'sd1);

   // Special-case priority, then overflow per mode, then flush, then the normal result.
   always_comb begin
      result = '0;
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
         result = bf16_t'(BF16_QNAN);
      end else if (a_inf || b_inf) begin
         result = bf16_t'({sign, 8'hFF, 7'h00});
      end else if (a_zero || b_zero) begin
         result = bf16_t'({sign, 15'h0000});
      end else if (ovf) begin
         case (mode)
            RNE:     result = bf16_t'({sign, 8'hFF, 7'h00});
            RTZ:     result = bf16_t'({sign, BF16_MAXF});
            RUP:     result = sign ? bf16_t'({1'b1, BF16_MAXF}) : bf16_t'({1'b0, 8'hFF, 7'h00});
            RDN:     result = sign ? bf16_t'({1'b1, 8'hFF, 7'h00}) : bf16_t'({1'b0, BF16_MAXF});
            default: result = bf16_t'({sign, 8'hFF, 7'h00});
         endcase
      end else if (unf) begin
         result = bf16_t'({sign, 15'h0000});
      end else begin
         result = bf16_t'({sign, exp_rnd[7:0], frac_sum[6:0]});
      end
   end

endmodule

// File: rtl/mul_chain_bf16.sv
// Pipelined chain computing p_k = a * b^(k+1); each stage multiplies the previous
// lane by the b that travels alongside the item, one stage per clock.
module mul_chain_bf16
   import mul_chain_pkg::*;
#(
   parameter int N_STAGES = N_STAGES_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           mul_ins,
   input  logic                  mul_stb,
   input  logic [1:0]            mode,
   output logic [32*N_STAGES-1:0] outputs,
   output logic [N_STAGES-1:0]   final_output_stbs
);

   bf16_t       lane_q [N_STAGES];
   bf16_t       b_q    [N_STAGES];
   round_mode_e mode_q [N_STAGES];
   logic [N_STAGES-1:0] vld_q;

   bf16_t       a_in   [N_STAGES];
   bf16_t       b_in   [N_STAGES];
   round_mode_e m_in   [N_STAGES];
   logic [N_STAGES-1:0] v_in;
   bf16_t       res    [N_STAGES];

   // Stage 0 takes the fresh operands; every later stage takes its predecessor's registers.
   always_comb begin
      a_in[0] = bf16_t'(mul_ins[31:16]);
      b_in[0] = bf16_t'(mul_ins[15:0]);
      m_in[0] = round_mode_e'(mode);
      v_in    = '0;
      v_in[0] = mul_stb;
      for (int k = 1; k < N_STAGES; k++) begin
         a_in[k] = lane_q[k-1];
         b_in[k] = b_q[k-1];
         m_in[k] = mode_q[k-1];
         v_in[k] = vld_q[k-1];
      end
   end

   for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
      bf16_mul u_mul (
         .a      (a_in[k]),
         .b      (b_in[k]),
         .mode   (m_in[k]),
         .result (res[k])
      );
   end

   // Pipeline registers: valids advance every cycle, data only loads with its valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         for (int k = 0; k < N_STAGES; k++) begin
            lane_q[k] <= '0;
            b_q[k]    <= '0;
            mode_q[k] <= RNE;
         end
      end else begin
         vld_q <= v_in;
         for (int k = 0; k < N_STAGES; k++) begin
            if (v_in[k]) begin
               lane_q[k] <= res[k];
               b_q[k]    <= b_in[k];
               mode_q[k] <= m_in[k];
            end
         end
      end
   end

   // Lanes are presented as fp32 with the bf16 in the upper half.
   always_comb begin
      outputs = '0;
      for (int k = 0; k < N_STAGES; k++) begin
         outputs[32*k +: 32] = {lane_q[k], 16'h0000};
      end
   end

   assign final_output_stbs = vld_q;

endmodule

// File: tb/tb_mul_chain_bf16.sv
// Scoreboard bench for mul_chain_bf16: stimulus pushes expected lane values and pulse
// cycles per lane; a negedge monitor pops and compares whenever a lane strobes.
module tb_mul_chain_bf16;

   localparam int NS = 6;

   logic             clk = 1'b0;
   logic             rst;
   logic [31:0]      mul_ins;
   logic             mul_stb;
   logic [1:0]       mode;
   logic [32*NS-1:0] outputs;
   logic [NS-1:0]    stbs;

   always #5 clk = ~clk;

   mul_chain_bf16 #(.N_STAGES(NS)) dut (
      .clk               (clk),
      .rst               (rst),
      .mul_ins           (mul_ins),
      .mul_stb           (mul_stb),
      .mode              (mode),
      .outputs           (outputs),
      .final_output_stbs (stbs)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [15:0] val;
      int          cyc;
   } exp_t;

   exp_t          sbq [NS][$];
   logic [15:0]   hand [NS];
   logic [NS-1:0] hand_en;
   logic [NS-1:0] lane_en;

   // Reference: exact integer product, rounded by comparing the discarded remainder to half an ulp.
   function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                           input logic [1:0] md);
      int ea, eb, fa, fb, m, e, sh, q, rem, half, inc;
      logic s;
      ea = int'(a[14:7]); eb = int'(b[14:7]);
      fa = int'(a[6:0]);  fb = int'(b[6:0]);
      s  = a[15] ^ b[15];
      if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0) ||
          (ea == 255 && eb == 0) || (eb == 255 && ea == 0)) return 16'h7FC0;
      if (ea == 255 || eb == 255) return {s, 15'h7F80};
      if (ea == 0 || eb == 0) return {s, 15'h0000};
      m  = (128 + fa) * (128 + fb);
      e  = ea + eb - 127;
      sh = 7;
      if (m >= 32768) begin sh = 8; e = e + 1; end
      q    = m >> sh;
      rem  = m - (q << sh);
      half = 1 << (sh - 1);
      case (md)
         2'd0:    inc = ((rem > half) || (rem == half && (q % 2) == 1)) ? 1 : 0;
         2'd1:    inc = 0;
         2'd2:    inc = (!s && rem != 0) ? 1 : 0;
         default: inc = (s && rem != 0) ? 1 : 0;
      endcase
      q = q + inc;
      if (q == 256) begin q = 128; e = e + 1; end
      if (e >= 255) begin
         case (md)
            2'd0:    return {s, 15'h7F80};
            2'd1:    return {s, 15'h7F7F};
            2'd2:    return s ? 16'hFF7F : 16'h7F80;
            default: return s ? 16'hFF80 : 16'h7F7F;
         endcase
      end
      if (e <= 0) return {s, 15'h0000};
      return {s, e[7:0], q[6:0]};
   endfunction

   // Monitor: every strobe must match the oldest expected entry for its lane, value and cycle.
   always @(negedge clk) begin
      exp_t e;
      for (int k = 0; k < NS; k++) begin
         if (stbs[k]) begin
            n_cmp++;
            if (sbq[k].size() == 0) begin
               n_bad++;
               $display("FAIL lane%0d_unexpected_pulse: got value %h at cycle %0d, required no pulse",
                        k, outputs[32*k +: 32], cyc);
            end else begin
               e = sbq[k].pop_front();
               if (outputs[32*k +: 32] !== {e.val, 16'h0000} || cyc != e.cyc) begin
                  n_bad++;
                  $display("FAIL lane%0d_value: got %h at cycle %0d, required %h at cycle %0d",
                           k, outputs[32*k +: 32], cyc, {e.val, 16'h0000}, e.cyc);
               end
            end
         end
      end
   end

   task automatic send(input logic [31:0] ins, input logic [1:0] md);
      logic [15:0] p;
      p = ins[31:16];
      @(negedge clk);
      mul_ins = ins;
      mode    = md;
      mul_stb = 1'b1;
      for (int k = 0; k < NS; k++) begin
         p = ref_mul(p, ins[15:0], md);
         if (lane_en[k]) sbq[k].push_back('{val: (hand_en[k] ? hand[k] : p), cyc: cyc + k + 1});
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         mul_stb = 1'b0;
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (t < 60 && (sbq[0].size() + sbq[1].size() + sbq[2].size() +
                        sbq[3].size() + sbq[4].size() + sbq[5].size()) != 0) begin
         @(negedge clk);
         t++;
      end
      for (int k = 0; k < NS; k++) begin
         n_cmp++;
         if (sbq[k].size() != 0) begin
            n_bad++;
            $display("FAIL lane%0d_missing_pulses: got %0d outstanding, required 0", k, sbq[k].size());
            sbq[k].delete();
         end
      end
   endtask

   task automatic one(input logic [31:0] ins, input logic [1:0] md);
      send(ins, md);
      idle(1);
      drain();
   endtask

   task automatic check(input string nm, input logic [32*NS-1:0] got, input logic [32*NS-1:0] req);
      n_cmp++;
      if (got !== req) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", nm, got, req);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: still running at %0t, required finish", $time);
      $fatal(1);
   end

   initial begin
      rst     = 1'b1;
      mul_stb = 1'bx;
      mul_ins = 'x;
      mode    = 'x;
      lane_en = '1;
      hand_en = '0;
      for (int k = 0; k < NS; k++) hand[k] = 16'h0000;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst     = 1'b0;
      mul_stb = 1'b0;
      mul_ins = 32'h0;
      mode    = 2'b00;
      check("reset_lanes", outputs, '0);
      check("reset_stbs", {{(32*NS-NS){1'b0}}, stbs}, '0);

      // Power chain 1.0 * 2.0^(k+1)
      hand[0] = 16'h4000; hand[1] = 16'h4080; hand[2] = 16'h4100;
      hand[3] = 16'h4180; hand[4] = 16'h4200; hand[5] = 16'h4280;
      hand_en = '1;
      one(32'h3F804000, 2'b00);

      // Rounding of 0x3F81 squared under each mode
      hand_en = 6'b000001;
      hand[0] = 16'h3F82; one(32'h3F813F81, 2'b00);
      hand[0] = 16'h3F82; one(32'h3F813F81, 2'b01);
      hand[0] = 16'h3F83; one(32'h3F813F81, 2'b10);
      hand[0] = 16'h3F82; one(32'h3F813F81, 2'b11);

      // Overflow handling per mode
      hand[0] = 16'h7F80; one(32'h7F004000, 2'b00);
      hand[0] = 16'h7F7F; one(32'h7F004000, 2'b11);
      hand[0] = 16'h7F7F; one(32'h7F004000, 2'b01);

      // Specials
      for (int k = 0; k < NS; k++) hand[k] = 16'h7FC0;
      hand_en = '1;
      one(32'h7F800000, 2'b00);
      hand_en = 6'b000001; hand[0] = 16'h0000;
      one(32'h00013F80, 2'b00);
      hand_en = 6'b100000; hand[5] = 16'hC280;
      one(32'hBF804000, 2'b00);

      // Streaming: 16 back-to-back items, round toward -inf, mixed signs
      hand_en = '0;
      for (int i = 0; i < 16; i++) begin
         logic [15:0] av, bv;
         av = 16'h3FA0 + 16'(i * 19);
         bv = 16'h3F81 + 16'(i * 5);
         av[15] = i[0];
         bv[15] = i[1];
         send({av, bv}, 2'b11);
      end
      idle(1);
      drain();

      // Reset while an item is in flight: only lanes 0 and 1 may pulse
      lane_en = 6'b000011;
      send(32'h3FC04040, 2'b00);
      idle(1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midreset_lanes", outputs, '0);
      check("midreset_stbs", {{(32*NS-NS){1'b0}}, stbs}, '0);
      @(negedge clk);
      rst = 1'b0;
      lane_en = '1;
      idle(10);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
